// File: rtl/rv_lsu_bus_ctrl.sv
// rtl/rv_lsu_bus_ctrl.sv - load/store bus controller: lane steering, valid/ready transaction, stall, read alignment.
// Optional feature: define RV_LSU_MISALIGN_TRAP_EN to abort misaligned accesses without touching the bus.
module rv_lsu_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_err,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam bit         LP_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_off_eff;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [1:0]  w_off_eff;
    logic [31:0] w_rdata_aligned;
    logic        w_trap_req;
    logic        w_accept;
    logic        w_trap;
    logic        w_bus_done;
    logic        w_timeout;
    logic        w_unused;

    assign w_size   = i_funct3[1:0];
    assign w_off    = i_req_addr[1:0];
    assign w_unused = i_funct3[2];

    // Lane steering; size code 11 falls through to word handling.
    always_comb begin
        w_be      = 4'b1111;
        w_wdata   = i_req_wdata;
        w_off_eff = 2'b00;
        case (w_size)
            2'b00: begin
                w_be      = 4'b0001 << w_off;
                w_wdata   = {4{i_req_wdata[7:0]}};
                w_off_eff = w_off;
            end
            2'b01: begin
                w_be      = 4'b0011 << {w_off[1], 1'b0};
                w_wdata   = {2{i_req_wdata[15:0]}};
                w_off_eff = {w_off[1], 1'b0};
            end
            default: begin
                w_be      = 4'b1111;
                w_wdata   = i_req_wdata;
                w_off_eff = 2'b00;
            end
        endcase
    end

`ifdef RV_LSU_MISALIGN_TRAP_EN
    assign w_trap_req = (w_size == 2'b00) ? 1'b0 :
                        (w_size == 2'b01) ? w_off[0] :
                                            (w_off != 2'b00);
`else
    assign w_trap_req = 1'b0;
`endif

    assign w_rdata_aligned = i_bus_rdata >> {r_off_eff, 3'b000};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_trap      = 1'b0;
        w_bus_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (w_trap_req) begin
                        w_trap      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (i_bus_ready) begin
                    w_bus_done  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and response capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_off_eff <= 2'd0;
            r_cnt     <= 8'd0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we      <= i_req_we;
                r_addr    <= {i_req_addr[31:2], 2'b00};
                r_wdata   <= w_wdata;
                r_be      <= w_be;
                r_off_eff <= w_off_eff;
                r_cnt     <= 8'd0;
            end else if (r_state == ST_BUS) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_trap || w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= 32'd0;
            end else if (w_bus_done) begin
                r_err   <= 1'b0;
                r_rdata <= r_we ? 32'd0 : w_rdata_aligned;
            end
        end
    end

    assign o_stall     = ((r_state == ST_IDLE) && i_req_valid) || (r_state == ST_BUS);
    assign o_bus_valid = (r_state == ST_BUS);
    assign o_rsp_valid = (r_state == ST_DONE);
    assign o_rsp_rdata = r_rdata;
    assign o_err       = r_err;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_be    = r_be;

endmodule

// File: tb/tb_rv_lsu_bus_ctrl.sv
// tb/tb_rv_lsu_bus_ctrl.sv - self-checking bench for rv_lsu_bus_ctrl (vector table, corner sequences, random vs model).
module tb_rv_lsu_bus_ctrl;

    localparam int T = 4;
`ifdef RV_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  funct3;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv_lsu_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_we    (req_we),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_funct3    (funct3),
        .o_stall     (stall),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_err       (err),
        .o_bus_valid (bus_valid),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_be    (bus_be),
        .i_bus_ready (bus_ready),
        .i_bus_rdata (bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] e_baddr;
        logic [3:0]  e_be;
        logic [31:0] e_bwd;
        logic [31:0] e_rsp;
        logic        e_err;
        int          e_lat;
        int          e_nbus;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: size in bytes, the naturally aligned group holding the address, timeout after T waits.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] d,
                         input logic [2:0] f3, input int waits, input logic [31:0] rdata,
                         output logic [31:0] baddr, output logic [3:0] be, output logic [31:0] bwd,
                         output logic [31:0] rsp, output logic e, output int lat, output int nbus);
        int n;
        int off;
        int base;
        n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(addr % 4);
        base = (off / n) * n;
        baddr = addr - 32'(off);
        be  = 4'd0;
        bwd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= base && i < base + n) be[i] = 1'b1;
            bwd[8*i +: 8] = d[8*(i % n) +: 8];
        end
        if (TRAP && (off % n != 0)) begin
            e = 1'b1; rsp = 32'd0; lat = 2; nbus = 0;
        end else if (waits >= T) begin
            e = 1'b1; rsp = 32'd0; lat = T + 2; nbus = T;
        end else begin
            e = 1'b0; rsp = we ? 32'd0 : (rdata >> (8 * base)); lat = waits + 3; nbus = waits + 1;
        end
    endtask

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_access(input string tag, input vec_t v);
        int  cyc;
        int  k;
        int  stall_cnt;
        int  nbus;
        bit  got;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        funct3    = v.f3;
        cyc = 1; k = 0; stall_cnt = 0; nbus = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_valid) begin
                nbus++;
                chk({tag, " bus_addr"}, bus_addr, v.e_baddr);
                chk({tag, " bus_be"}, 32'(bus_be), 32'(v.e_be));
                chk({tag, " bus_wdata"}, bus_wdata, v.e_bwd);
                chk({tag, " bus_we"}, 32'(bus_we), 32'(v.we));
                bus_ready = (k == v.waits);
                bus_rdata = (k == v.waits) ? v.rdata : $urandom;
                k++;
            end else begin
                bus_ready = 1'($urandom);
                bus_rdata = $urandom;
            end
            if (rsp_valid) begin
                got = 1'b1;
                chk({tag, " latency"}, 32'(cyc), 32'(v.e_lat));
                chk({tag, " err"}, 32'(err), 32'(v.e_err));
                chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rsp);
                chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
                chk({tag, " bus_valid_in_done"}, 32'(bus_valid), 32'd0);
            end
            @(posedge clk);
            #1;
            if (cyc == 1) req_valid = 1'b0;
            cyc++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s: no rsp_valid within 40 cycles", tag);
        end else begin
            chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.e_lat - 1));
            chk({tag, " bus_cycles"}, 32'(nbus), 32'(v.e_nbus));
        end
        req_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] d,
                                input logic [2:0] f3, input int w, input logic [31:0] rd,
                                input logic [31:0] ba, input logic [3:0] be, input logic [31:0] bwd,
                                input logic [31:0] rsp, input logic e, input int lat, input int nb);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = d; v.f3 = f3; v.waits = w; v.rdata = rd;
        v.e_baddr = ba; v.e_be = be; v.e_bwd = bwd; v.e_rsp = rsp; v.e_err = e;
        v.e_lat = lat; v.e_nbus = nb;
        return v;
    endfunction

    initial begin
        vec_t v;
        bit [5:0] bv_pat;
        bit [5:0] rv_pat;

        tbl[0]  = mk(1, 32'h1003, 32'h000000A5, 3'd0, 0,  32'h0,        32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 3, 1);
        tbl[1]  = mk(0, 32'h2002, 32'h11223344, 3'd1, 3,  32'hBEEF1234, 32'h2000, 4'b1100, 32'h33443344, 32'h0000BEEF, 0, 6, 4);
        tbl[2]  = mk(0, 32'h0100, 32'hCAFEF00D, 3'd2, 99, 32'h12345678, 32'h0100, 4'b1111, 32'hCAFEF00D, 32'h0,        1, 6, 4);
        tbl[3]  = mk(1, 32'h4000, 32'hDEADBEEF, 3'd2, 1,  32'h0,        32'h4000, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 4, 2);
        tbl[4]  = mk(0, 32'h5001, 32'h000000FF, 3'd0, 0,  32'h11223344, 32'h5000, 4'b0010, 32'hFFFFFFFF, 32'h00112233, 0, 3, 1);
        tbl[5]  = mk(1, 32'h6000, 32'h1234CAFE, 3'd1, 2,  32'h0,        32'h6000, 4'b0011, 32'hCAFECAFE, 32'h0,        0, 5, 3);
        tbl[6]  = mk(0, 32'h7000, 32'h0,        3'd3, 0,  32'h89ABCDEF, 32'h7000, 4'b1111, 32'h0,        32'h89ABCDEF, 0, 3, 1);
        tbl[7]  = mk(0, 32'h8002, 32'h0,        3'd4, 0,  32'hA1B2C3D4, 32'h8000, 4'b0100, 32'h0,        32'h0000A1B2, 0, 3, 1);
        tbl[8]  = mk(1, 32'hA000, 32'h0000005A, 3'd0, 4,  32'h0,        32'hA000, 4'b0001, 32'h5A5A5A5A, 32'h0,        1, 6, 4);
`ifdef RV_LSU_MISALIGN_TRAP_EN
        tbl[9]  = mk(0, 32'h3001, 32'hA0B0C0D0, 3'd2, 0,  32'h55667788, 32'h3000, 4'b1111, 32'hA0B0C0D0, 32'h0,        1, 2, 0);
        tbl[10] = mk(1, 32'h9003, 32'h0000BBAA, 3'd1, 0,  32'h0,        32'h9000, 4'b1100, 32'hBBAABBAA, 32'h0,        1, 2, 0);
`else
        tbl[9]  = mk(0, 32'h3001, 32'hA0B0C0D0, 3'd2, 0,  32'h55667788, 32'h3000, 4'b1111, 32'hA0B0C0D0, 32'h55667788, 0, 3, 1);
        tbl[10] = mk(1, 32'h9003, 32'h0000BBAA, 3'd1, 0,  32'h0,        32'h9000, 4'b1100, 32'hBBAABBAA, 32'h0,        0, 3, 1);
`endif

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        funct3 = 3'd0; bus_ready = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset bus_valid", 32'(bus_valid), 32'd0);
        chk("reset bus_we", 32'(bus_we), 32'd0);
        chk("reset bus_addr", bus_addr, 32'd0);
        chk("reset bus_wdata", bus_wdata, 32'd0);
        chk("reset bus_be", 32'(bus_be), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_access($sformatf("vec%0d", i), tbl[i]);

        // Reset during a stalled bus wait.
        bus_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hB000; funct3 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        chk("midrst pre bus_valid", 32'(bus_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst bus_valid", 32'(bus_valid), 32'd0);
        chk("midrst stall", 32'(stall), 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst after rsp_valid", 32'(rsp_valid), 32'd0);
        run_access("after_rst", tbl[0]);

        // Back-to-back requests with req_valid held and an always-ready slave.
        bus_ready = 1'b1; bus_rdata = 32'h01020304;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC000; req_wdata = 32'h77; funct3 = 3'd0;
        bv_pat = '0; rv_pat = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bv_pat[c] = bus_valid;
            rv_pat[c] = rsp_valid;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; bus_ready = 1'b0;
        chk("b2b bus_valid pattern", 32'(bv_pat), 32'b010010);
        chk("b2b rsp_valid pattern", 32'(rv_pat), 32'b100100);
        @(posedge clk); #1;

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.we    = 1'($urandom);
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.f3    = 3'($urandom);
            v.waits = $urandom_range(0, 5);
            v.rdata = $urandom;
            model(v.we, v.addr, v.wdata, v.f3, v.waits, v.rdata,
                  v.e_baddr, v.e_be, v.e_bwd, v.e_rsp, v.e_err, v.e_lat, v.e_nbus);
            run_access($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_lsu_bus_ctrl.md
# rv_lsu_bus_ctrl

Load/store bus controller between the core's execute stage and the data-memory/MMIO bus (data RAM, UART registers). It steers store data onto byte lanes with byte enables and issues one bus transaction per access over a valid/ready handshake. It stalls the core until the transaction completes and right-aligns read data so the load extension unit receives the addressed byte or halfword in bits [15:0]/[7:0].

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles waited for `bus_ready` before aborting with error. Range 1..255; 0 disables the timeout.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `req_valid` in 1: core presents a load/store this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `funct3` in 3: access size; [1:0] 00 = byte, 01 = half, 10 = word. Bit 2 is ignored here.
- `stall` out 1: hold the core's PC/pipeline.
- `rsp_valid` out 1: one-cycle pulse; access complete.
- `rsp_rdata` out 32: read word shifted right by 8×addr[1:0]; valid with `rsp_valid` on loads.
- `err` out 1: abort flag, valid with `rsp_valid`.
- `bus_valid` out 1: transaction request.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: word address, {req_addr[31:2], 2'b00}.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables, also driven on reads.
- `bus_ready` in 1: slave accepts/completes; `bus_rdata` valid the same cycle on reads.
- `bus_rdata` in 32: read word.

## Operation
- **States:** IDLE, BUS, DONE.
- **Reset:**
  - State returns to IDLE.
  - All outputs, the timeout counter and the latched request registers are 0.
- **IDLE:**
  - `stall` = `req_valid` (combinational).
  - On `req_valid`, latch we/addr/wdata/size/be, clear the counter and go to BUS.
  - With `MISALIGN_TRAP_EN` and a misaligned request, go directly to DONE with err=1.
- **BUS:**
  - `bus_valid`=1 and `stall`=1; all bus outputs come from the latched registers and stay stable until `bus_ready`.
  - If `bus_ready`=1: capture the shifted `bus_rdata` (stores capture 0), set err=0, go to DONE.
  - Else, if the counter equals `TIMEOUT_CYCLES`-1 and the timeout is enabled: set err=1, set rdata=0, go to DONE.
  - Else increment the counter.
- **DONE:**
  - `rsp_valid`=1 and `stall`=0, so the core retires the instruction on this edge.
  - Go to IDLE unconditionally; `req_valid` is ignored in DONE. This gives a one-cycle minimum gap between accesses.
- **Lane mapping** (off = addr[1:0]):
  - Byte: be = 0001<<off; wdata = {4{d[7:0]}}.
  - Half: be = 0011<<(off[1]×2); wdata = {2{d[15:0]}}.
  - Word: be = 1111; wdata = d.
- **Read alignment:** `rsp_rdata` = `bus_rdata` >> (8×off_eff).
  - off_eff = off for byte, {off[1],0} for half, 0 for word.
- **Misaligned:** half with off[0]=1, or word with off≠0.
- **Unused encoding:** `funct3`[1:0]=11 is treated as word.

## Timing
- Zero-wait slave (`bus_ready` high in the first BUS cycle): request edge → BUS → DONE; 3 cycles from IDLE acceptance to the core advancing, with `stall` high for 2 cycles.
- N wait cycles add N cycles to the stall.
- Timeout: `rsp_valid` arrives `TIMEOUT_CYCLES`+1 cycles after acceptance.
- `bus_ready` outside BUS is ignored.
- `rsp_valid` and `err` are registered (state-decoded); `stall` in IDLE is combinational from `req_valid`.
- Reset asserted mid-BUS: `bus_valid` drops immediately (asynchronous), and no response is produced.

## Configuration
- `RV_LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests never reach the bus.
  - The FSM goes IDLE→DONE with err=1 and rsp_rdata=0; latency 2 cycles.
- Not defined:
  - Misaligned requests are issued with truncated offsets: half uses off[1], word uses offset 0.
  - `err` is set only on timeout.

## Test plan
- Store byte 0xA5 at 0x1003, zero-wait slave: bus_addr=0x1000, be=1000, wdata=0xA5A5A5A5; `rsp_valid` on cycle 3 with err=0.
- Load half at 0x2002, bus_rdata=0xBEEF1234 after 3 wait cycles: rsp_rdata=0x0000BEEF, `stall` high for 5 cycles.
- Load word with `bus_ready` never asserted, TIMEOUT_CYCLES=4: `rsp_valid` 5 cycles after acceptance, err=1, rsp_rdata=0, `bus_valid` deasserted in DONE.
- Load word at 0x3001:
  - With macro: no `bus_valid` ever, err=1 on cycle 2.
  - Without macro: bus_addr=0x3000, be=1111, err=0.
- `rst` pulsed during a BUS wait: `bus_valid`, `stall` and `rsp_valid` go to 0 immediately; the next `req_valid` is accepted normally.
- Back-to-back requests with `req_valid` held through DONE: exactly one bus transaction per instruction, one idle cycle between transactions.
